// File: rtl/if_id_queue.sv
// if_id_queue: fetch-to-decode buffer. A small circular FIFO of {instr, pc}
// beats; the head is presented to decode along with its decoded immediate
// fields and register indices.
//
// Handshake: a beat transfers on a rising edge where in_valid & in_ready & ~flush.
// in_ready is a function of the occupancy only, so fetch sees no combinational
// path from stall or flush. Decode consumes the head on an edge where
// out_valid & ~stall & ~flush. flush discards every entry as well as any push
// or pop in the same cycle.
module if_id_queue #(
    parameter int          DEPTH = 2,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        stall,
    input  logic        flush,
    output logic        out_valid,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic [11:0] iimm,
    output logic [11:0] simm,
    output logic [11:0] bimm,
    output logic [19:0] uimm,
    output logic [19:0] jimm,
    output logic [4:0]  shamt,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_pc    [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    assign in_ready  = (count < FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & ~stall & ~flush;

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; never cleared, validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= in_instr;
            mem_pc[wr_ptr]    <= in_pc;
        end
    end

    // Head selection: an empty queue presents a NOP at PC 0.
    always_comb begin
        instrD = NOP;
        pcD    = '0;
        if (out_valid) begin
            instrD = mem_instr[rd_ptr];
            pcD    = mem_pc[rd_ptr];
        end
    end

    // Immediate and register fields are pure slices of the presented instruction.
    assign iimm  = instrD[31:20];
    assign simm  = {instrD[31:25], instrD[11:7]};
    assign bimm  = {instrD[31], instrD[7], instrD[30:25], instrD[11:8]};
    assign uimm  = instrD[31:12];
    assign jimm  = {instrD[31], instrD[19:12], instrD[20], instrD[30:21]};
    assign shamt = instrD[24:20];
    assign rs1   = instrD[19:15];
    assign rs2   = instrD[24:20];
    assign rd    = instrD[11:7];

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH=2): reset, single beat, stall/full,
// field decode, flush and a streaming run checked against an expected queue.
module tb_if_id_queue;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [11:0] iimm;
    logic [11:0] simm;
    logic [11:0] bimm;
    logic [19:0] uimm;
    logic [19:0] jimm;
    logic [4:0]  shamt;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_pc_q[$];

    if_id_queue #(.DEPTH(2), .NOP(NOP)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .stall(stall), .flush(flush),
        .out_valid(out_valid), .instrD(instrD), .pcD(pcD),
        .iimm(iimm), .simm(simm), .bimm(bimm), .uimm(uimm), .jimm(jimm),
        .shamt(shamt), .rs1(rs1), .rs2(rs2), .rd(rd)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic st, input logic fl);
        in_valid = v;
        in_instr = ins;
        in_pc    = pc;
        stall    = st;
        flush    = fl;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (instrD !== NOP) begin n_fail++; $display("FAIL reset_instrD got=%h exp=%h", instrD, NOP); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        rst = 1'b0;
        // fill to count=2 while stalled, then reset asynchronously mid-cycle
        drive(1'b1, 32'h11111111, 32'h40, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h22222222, 32'h44, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL prereset_full got=%b exp=0", in_ready); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (instrD !== NOP) begin n_fail++; $display("FAIL midreset_instrD got=%h exp=%h", instrD, NOP); end
        n_checks++; if (pcD !== 32'h0) begin n_fail++; $display("FAIL midreset_pcD got=%h exp=0", pcD); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready got=%b exp=1", in_ready); end
        step();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_single_beat();
        drive(1'b1, 32'h00500093, 32'h0, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
        n_checks++; if (instrD !== 32'h00500093) begin n_fail++; $display("FAIL single_instrD got=%h exp=00500093", instrD); end
        n_checks++; if (iimm !== 12'h005) begin n_fail++; $display("FAIL single_iimm got=%h exp=005", iimm); end
        n_checks++; if (rd !== 5'd1) begin n_fail++; $display("FAIL single_rd got=%0d exp=1", rd); end
        n_checks++; if (rs1 !== 5'd0) begin n_fail++; $display("FAIL single_rs1 got=%0d exp=0", rs1); end
        n_checks++; if (pcD !== 32'h0) begin n_fail++; $display("FAIL single_pcD got=%h exp=0", pcD); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_popped got=%b exp=0", out_valid); end
        n_checks++; if (iimm !== 12'h000) begin n_fail++; $display("FAIL empty_iimm got=%h exp=000", iimm); end
        n_checks++; if (rd !== 5'd0) begin n_fail++; $display("FAIL empty_rd got=%0d exp=0", rd); end
    endtask

    task automatic test_stall_full();
        drive(1'b1, 32'hAAAA0004, 32'h04, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'hAAAA0008, 32'h08, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'hAAAA000C, 32'h0C, 1'b1, 1'b0);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (pcD !== 32'h04) begin n_fail++; $display("FAIL stall_head0 got=%h exp=04", pcD); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_hold got=%b exp=0", in_ready); end
        step();
        n_checks++; if (pcD !== 32'h08 || instrD !== 32'hAAAA0008) begin n_fail++; $display("FAIL stall_head1 got=%h/%h exp=08/aaaa0008", pcD, instrD); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL one_left_ready got=%b exp=1", in_ready); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drained got=%b exp=0 (0C must not be admitted)", out_valid); end
    endtask

    task automatic test_fields();
        drive(1'b1, 32'hFE512E23, 32'h100, 1'b1, 1'b0);
        step();
        n_checks++; if (simm !== 12'hFFC) begin n_fail++; $display("FAIL sw_simm got=%h exp=ffc", simm); end
        n_checks++; if (rs1 !== 5'd2) begin n_fail++; $display("FAIL sw_rs1 got=%0d exp=2", rs1); end
        n_checks++; if (rs2 !== 5'd5) begin n_fail++; $display("FAIL sw_rs2 got=%0d exp=5", rs2); end
        // push and pop on the same edge
        drive(1'b1, 32'h008000EF, 32'h104, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_checks++; if (jimm !== 20'h00004) begin n_fail++; $display("FAIL jal_jimm got=%h exp=00004", jimm); end
        n_checks++; if (rd !== 5'd1) begin n_fail++; $display("FAIL jal_rd got=%0d exp=1", rd); end
        n_checks++; if (uimm !== 20'h00800) begin n_fail++; $display("FAIL jal_uimm got=%h exp=00800", uimm); end
        n_checks++; if (pcD !== 32'h104) begin n_fail++; $display("FAIL jal_pcD got=%h exp=104", pcD); end
        step();
        n_checks++; if (pcD !== 32'h104) begin n_fail++; $display("FAIL jal_stalled got=%h exp=104", pcD); end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fields_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h0000A001, 32'h200, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h0000A002, 32'h204, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h0000A003, 32'h208, 1'b1, 1'b1);
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_full_valid got=%b exp=0", out_valid); end
        n_checks++; if (instrD !== NOP || pcD !== 32'h0) begin n_fail++; $display("FAIL flush_full_head got=%h/%h exp=%h/0", instrD, pcD, NOP); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_full_ready got=%b exp=1", in_ready); end
        // count=1 with a push offered: flush must drop the beat
        drive(1'b1, 32'h0000B001, 32'h300, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h0000B002, 32'h304, 1'b0, 1'b1);
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_push_dropped got=%b exp=0", out_valid); end
        drive(1'b1, 32'h0000B003, 32'h308, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (instrD !== 32'h0000B003 || pcD !== 32'h308) begin n_fail++; $display("FAIL after_flush_head got=%h/%h exp=0000b003/308", instrD, pcD); end
        step();
    endtask

    task automatic test_streaming();
        logic [31:0] ins;
        exp_q.delete();
        exp_pc_q.delete();
        for (int i = 0; i < 20; i++) begin
            ins = $urandom;
            drive(1'b1, ins, 32'h1000 + 32'(i * 4), 1'b0, 1'b0);
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready beat=%0d got=%b exp=1", i, in_ready); end
            if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                void'(exp_pc_q.pop_front());
            end
            exp_q.push_back(ins);
            exp_pc_q.push_back(32'h1000 + 32'(i * 4));
            step();
            n_checks++;
            if (out_valid !== 1'b1 || instrD !== exp_q[0] || pcD !== exp_pc_q[0]) begin
                n_fail++;
                $display("FAIL stream_head beat=%0d got=%b/%h/%h exp=1/%h/%h", i, out_valid, instrD, pcD, exp_q[0], exp_pc_q[0]);
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        void'(exp_pc_q.pop_front());
        step();
        n_checks++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin n_fail++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_stall_full();
        test_fields();
        test_flush();
        test_streaming();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
